// File: rtl/alu_issue_seq.sv
// Issue sequencer: steps a small program through an external fixed-latency ALU and logs each result.
// Optional build macro ALU_SEQ_HALT_ON_OV_EN: end the run early (aborted=1) on the first captured overflow.
module alu_issue_seq #(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [15:0]              load_instr,
    input  logic [7:0]               load_d0,
    input  logic [7:0]               load_d1,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   length,
    output logic [15:0]              instruction,
    output logic [7:0]               data0,
    output logic [7:0]               data1,
    input  logic [7:0]               alu_out0,
    input  logic [7:0]               alu_out1,
    input  logic [7:0]               alu_out2,
    input  logic [7:0]               alu_out3,
    input  logic                     alu_ov,
    input  logic                     alu_z,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data,
    output logic [1:0]               rd_flags,
    output logic [3:0]               ov_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_prog [DEPTH];
    logic [33:0]   r_log  [DEPTH];
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_last;
    logic [2:0]    r_wcnt;
    logic [3:0]    r_ov_cnt;
    logic [15:0]   r_instr;
    logic [7:0]    r_d0;
    logic [7:0]    r_d1;
    logic [AW:0]   w_len;
    logic          w_last;
    logic          w_halt;
    logic [33:0]   w_rd_entry;

    assign w_len  = (length > DEPTH_V) ? DEPTH_V : length;
    assign w_last = (r_ptr == r_last);

`ifdef ALU_SEQ_HALT_ON_OV_EN
    logic r_aborted;

    assign w_halt  = alu_ov;
    assign aborted = r_aborted;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= (r_state == S_CAPT) && alu_ov;
        end
    end
`else
    assign w_halt  = 1'b0;
    assign aborted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy   = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_wcnt == 3'd1) begin
                    w_next = S_CAPT;
                end
            end
            S_CAPT: begin
                busy   = 1'b1;
                w_next = (w_last || w_halt) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Run control and the registered ALU drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_last   <= '0;
            r_wcnt   <= '0;
            r_ov_cnt <= '0;
            r_instr  <= '0;
            r_d0     <= '0;
            r_d1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr    <= '0;
                        r_ov_cnt <= '0;
                        r_last   <= AW'(w_len - 1'b1);
                    end
                end
                S_ISSUE: begin
                    {r_instr, r_d0, r_d1} <= r_prog[r_ptr];
                    r_wcnt                <= 3'(ALU_LAT);
                end
                S_WAIT: r_wcnt <= r_wcnt - 3'd1;
                S_CAPT: begin
                    if (alu_ov && (r_ov_cnt != 4'hF)) begin
                        r_ov_cnt <= r_ov_cnt + 4'd1;
                    end
                    if (!w_last) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    r_instr <= '0;
                    r_d0    <= '0;
                    r_d1    <= '0;
                end
                default: ;
            endcase
        end
    end

    // Program memory holds its contents through reset.
    always_ff @(posedge clk) begin
        if (rst && load_en && (r_state == S_IDLE)) begin
            r_prog[load_addr] <= {load_instr, load_d0, load_d1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_log[i] <= '0;
            end
        end else if (r_state == S_CAPT) begin
            r_log[r_ptr] <= {alu_out3, alu_out2, alu_out1, alu_out0, alu_ov, alu_z};
        end
    end

    assign w_rd_entry  = r_log[rd_addr];
    assign rd_data     = w_rd_entry[33:2];
    assign rd_flags    = w_rd_entry[1:0];
    assign instruction = r_instr;
    assign data0       = r_d0;
    assign data1       = r_d1;
    assign ov_count    = r_ov_cnt;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized bench for alu_issue_seq with an ALU stub and a run-level reference model.
module tb_alu_issue_seq;
    localparam int DEPTH   = 8;
    localparam int ALU_LAT = 1;
    localparam int AW      = $clog2(DEPTH);
`ifdef ALU_SEQ_HALT_ON_OV_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_instr = '0;
    logic [7:0]    load_d0 = '0;
    logic [7:0]    load_d1 = '0;
    logic          start = 1'b0;
    logic [AW:0]   length = '0;
    logic [15:0]   instruction;
    logic [7:0]    data0;
    logic [7:0]    data1;
    logic [7:0]    alu_out0;
    logic [7:0]    alu_out1;
    logic [7:0]    alu_out2;
    logic [7:0]    alu_out3;
    logic          alu_ov;
    logic          alu_z;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data;
    logic [1:0]    rd_flags;
    logic [3:0]    ov_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_instr [DEPTH];
    logic [7:0]  m_d0    [DEPTH];
    logic [7:0]  m_d1    [DEPTH];
    logic [33:0] m_log   [DEPTH];

    always #10 clk = ~clk;

    alu_issue_seq #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_instr(load_instr), .load_d0(load_d0), .load_d1(load_d1),
        .start(start), .length(length), .instruction(instruction),
        .data0(data0), .data1(data1), .alu_out0(alu_out0), .alu_out1(alu_out1),
        .alu_out2(alu_out2), .alu_out3(alu_out3), .alu_ov(alu_ov), .alu_z(alu_z),
        .busy(busy), .done(done), .aborted(aborted), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_flags(rd_flags), .ov_count(ov_count)
    );

    // ALU stub: ALU_LAT register stages on the drive, then the result function.
    logic [31:0] stg [ALU_LAT];
    logic [31:0] alu_in;
    logic [8:0]  alu_sum;

    always @(posedge clk) begin
        stg[0] <= {instruction, data0, data1};
        for (int i = 1; i < ALU_LAT; i++) stg[i] <= stg[i-1];
    end

    assign alu_in   = stg[ALU_LAT-1];
    assign alu_sum  = {1'b0, alu_in[15:8]} + {1'b0, alu_in[7:0]};
    assign alu_out0 = alu_sum[7:0];
    assign alu_out1 = alu_in[15:8] & alu_in[7:0];
    assign alu_out2 = alu_in[31:24];
    assign alu_out3 = alu_in[23:16];
    assign alu_ov   = alu_sum[8];
    assign alu_z    = (alu_sum[7:0] == 8'd0);

    task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            #1;
            check_eq($sformatf("%s_log%0d", tag, i), {rd_data, rd_flags}, m_log[i]);
        end
        rd_addr = '0;
    endtask

    task automatic load_entry(input int a, input logic [15:0] ins, input logic [7:0] x0, input logic [7:0] x1);
        @(negedge clk);
        load_en = 1'b1; load_addr = AW'(a); load_instr = ins; load_d0 = x0; load_d1 = x1;
        @(negedge clk);
        load_en = 1'b0;
        m_instr[a] = ins; m_d0[a] = x0; m_d1[a] = x1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b1; length = (AW+1)'(1);
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 34'(busy), 34'(0));
        check_eq("rst_done", 34'(done), 34'(0));
        check_eq("rst_instr", 34'(instruction), 34'(0));
        check_eq("rst_ovcnt", 34'(ov_count), 34'(0));
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_log[i] = '0;
        check_log("rst");
    endtask

    task automatic run_prog(input int len, input bit poke);
        int n, k, cyc, exp_cyc;
        bit halted, busy_ok;
        logic [3:0]  exp_ov;
        logic [8:0]  sum;
        logic [33:0] old0, new0;
        logic [15:0] ins0;

        n = (len > DEPTH) ? DEPTH : len;
        k = 0; halted = 1'b0; exp_ov = '0;
        old0 = m_log[0]; ins0 = m_instr[0];
        for (int i = 0; i < n; i++) begin
            sum = {1'b0, m_d0[i]} + {1'b0, m_d1[i]};
            m_log[i] = {m_instr[i][7:0], m_instr[i][15:8], m_d0[i] & m_d1[i], sum[7:0], sum[8], sum[7:0] == 8'd0};
            k++;
            if (sum[8] && exp_ov != 4'hF) exp_ov++;
            if (HALT && sum[8]) begin
                halted = 1'b1;
                break;
            end
        end
        new0 = m_log[0];
        exp_cyc = k * (ALU_LAT + 2) + 1;

        @(negedge clk);
        start = 1'b1; length = (AW+1)'(len);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; busy_ok = 1'b1;
        while (done !== 1'b1 && cyc <= exp_cyc + 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == 2 && k > 0)
                check_eq($sformatf("drive_instr_len%0d", len), 34'(instruction), 34'(ins0));
            if (cyc == ALU_LAT + 2 && k > 0) begin
                rd_addr = '0; #1;
                check_eq("rd_during_capt", {rd_data, rd_flags}, old0);
            end
            if (cyc == ALU_LAT + 3 && k > 0) begin
                rd_addr = '0; #1;
                check_eq("rd_after_capt", {rd_data, rd_flags}, new0);
            end
            if (poke && cyc == 2) begin
                load_en = 1'b1; load_addr = AW'($urandom); load_instr = 16'($urandom);
                load_d0 = 8'($urandom); load_d1 = 8'($urandom);
                start = 1'b1; length = (AW+1)'($urandom);
            end
            if (cyc == 3) begin
                load_en = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        load_en = 1'b0; start = 1'b0;
        check_eq($sformatf("done_cycle_len%0d", len), 34'((done === 1'b1) ? cyc : 0), 34'(exp_cyc));
        check_eq($sformatf("busy_in_run_len%0d", len), 34'(busy_ok), 34'(1));
        check_eq("busy_at_done", 34'(busy), 34'(0));
        check_eq("aborted", 34'(aborted), 34'(halted));
        check_eq("ov_count", 34'(ov_count), 34'(exp_ov));
        @(negedge clk);
        check_eq("done_one_cycle", 34'(done), 34'(0));
        check_eq("drive_cleared", 34'({instruction, data0, data1}), 34'(0));
        check_log($sformatf("run_len%0d", len));
    endtask

    task automatic reset_mid_run();
        int pulses;
        @(negedge clk);
        start = 1'b1; length = (AW+1)'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (ALU_LAT + 3) @(negedge clk);
        check_eq("mid_wait_busy", 34'(busy), 34'(1));
        check_eq("mid_wait_instr", 34'(instruction), 34'(m_instr[1]));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("abort_busy", 34'(busy), 34'(0));
        check_eq("abort_drive", 34'({instruction, data0, data1}), 34'(0));
        check_eq("abort_ovcnt", 34'(ov_count), 34'(0));
        pulses = 0;
        for (int i = 0; i < 4 * (ALU_LAT + 2); i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 34'(pulses), 34'(0));
        for (int i = 0; i < DEPTH; i++) m_log[i] = '0;
        check_log("abort");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        load_entry(0, 16'hF000, 8'd129, 8'd129);
        load_entry(1, 16'h0800, 8'd200, 8'd150);
        load_entry(2, 16'h5000, 8'hAA, 8'h55);
        for (int i = 3; i < DEPTH; i++) load_entry(i, 16'($urandom), 8'($urandom), 8'($urandom));
        run_prog(3, 1'b0);
        run_prog(0, 1'b0);
        run_prog(DEPTH + 3, 1'b1);
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                load_entry(int'($urandom_range(0, DEPTH - 1)), 16'($urandom), 8'($urandom), 8'($urandom));
            run_prog(int'($urandom_range(0, 2 * DEPTH - 1)), 1'($urandom));
        end
        reset_mid_run();
        run_prog(DEPTH, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
